// File: rtl/bka_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bka_pkg
// Description : Shared types and elaboration helpers for the pipelined
//               Brent-Kung adder: generate/propagate pair, prefix level
//               count, node placement and register-rank placement.
// Revision    : 1.0 - initial release
// ============================================================================
package bka_pkg;

  // Generate/propagate pair carried through the prefix tree.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Number of Brent-Kung prefix levels for a power-of-two width.
  function automatic int bk_levels(input int width);
    return 2 * $clog2(width) - 1;
  endfunction

  // Prefix level after which register rank k (1..stages) sits.
  function automatic int rank_level(input int k, input int levels, input int stages);
    return (k * levels + stages - 1) / stages;
  endfunction

  // Rank index that sits after prefix level lvl, or 0 when none does.
  function automatic int level_rank(input int lvl, input int levels, input int stages);
    int r;
    r = 0;
    for (int k = 1; k <= stages; k++) begin
      if (rank_level(k, levels, stages) == lvl) r = k;
    end
    return r;
  endfunction

  // True when bit idx holds a black cell at prefix level lvl (1-based).
  // Levels 1..log2w form the up-sweep, the rest the down-sweep.
  function automatic bit bk_is_node(input int lvl, input int idx, input int log2w);
    int j;
    if (lvl <= log2w) begin
      j = lvl;
      return ((idx + 1) % (1 << j)) == 0;
    end
    j = 2 * log2w - lvl;
    return (idx >= (1 << j)) && (((idx + 1) % (1 << j)) == (1 << (j - 1)));
  endfunction

  // Distance from a black cell to its low-side partner at level lvl.
  function automatic int bk_span(input int lvl, input int log2w);
    if (lvl <= log2w) return 1 << (lvl - 1);
    return 1 << (2 * log2w - lvl - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bka_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : bka_pipe_if
// Description : Operand/result valid-ready bus of the pipelined adder.
//               The ovf signal exists only when BKA_PIPE_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface bka_pipe_if #(
  parameter int WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef BKA_PIPE_OVF_EN
  logic             ovf;
`endif

  // Producer/consumer side of the adder.
  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef BKA_PIPE_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef BKA_PIPE_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout
  );
endinterface
`default_nettype wire

// File: rtl/bka_gp_cell.sv
`default_nettype none
// ============================================================================
// Module      : bka_gp_cell
// Description : Prefix black cell combining a high group with the adjacent
//               low group: g = gh | (ph & gl), p = ph & pl.
// Revision    : 1.0 - initial release
// ============================================================================
module bka_gp_cell
  import bka_pkg::*;
(
  input  gp_t hi_i,
  input  gp_t lo_i,
  output gp_t gp_o
);
  assign gp_o.g = hi_i.g | (hi_i.p & lo_i.g);
  assign gp_o.p = hi_i.p & lo_i.p;
endmodule
`default_nettype wire

// File: rtl/bka_pipe.sv
`default_nettype none
// ============================================================================
// Module      : bka_pipe
// Description : Pipelined Brent-Kung adder with valid/ready handshake.
//               STAGES register ranks are spread evenly over the prefix
//               levels; the last rank registers sum/cout directly.
//               Optional signed overflow output: define BKA_PIPE_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module bka_pipe
  import bka_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  bka_pipe_if.slave  bus
);
  localparam int LOG2W  = $clog2(WIDTH);
  localparam int LEVELS = bk_levels(WIDTH);

  // Per-beat information that travels beside the prefix tree.
  typedef struct packed {
    logic             valid;
    logic             cin;
`ifdef BKA_PIPE_OVF_EN
    logic             sa;
    logic             sb;
`endif
    logic [WIDTH-1:0] p;
  } side_t;

  logic             stall;
  logic             valid_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  side_t            side_in;
  side_t            side [0:STAGES-1];
  side_t            last;
  gp_t              cin_gp;
  gp_t [WIDTH-1:0]  raw_gp;
  gp_t [WIDTH-1:0]  fin;
  logic [WIDTH-1:0] fin_g;
  logic [WIDTH-1:0] fin_p;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             unused_fin_p;

  // The whole pipe freezes while a result waits for the consumer.
  assign stall        = valid_q && !bus.out_ready;
  assign bus.in_ready = !stall;

  // Sideband of the beat presented at the input.
  always_comb begin
    side_in       = '0;
    side_in.valid = bus.in_valid;
    side_in.cin   = bus.cin;
    side_in.p     = bus.a ^ bus.b;
`ifdef BKA_PIPE_OVF_EN
    side_in.sa    = bus.a[WIDTH-1];
    side_in.sb    = bus.b[WIDTH-1];
`endif
  end
  assign side[0] = side_in;

  // Bitwise generate/propagate of the operands.
  always_comb begin
    raw_gp = '0;
    for (int i = 0; i < WIDTH; i++) begin
      raw_gp[i].g = bus.a[i] & bus.b[i];
      raw_gp[i].p = bus.a[i] ^ bus.b[i];
    end
  end

  // Carry-in acts as a generate at position -1 with no propagate.
  assign cin_gp = '{g: bus.cin, p: 1'b0};

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    gp_t [WIDTH-1:0] node;

    if (l == 0) begin : g_init
      bka_gp_cell u_cin (
        .hi_i (raw_gp[0]),
        .lo_i (cin_gp),
        .gp_o (node[0])
      );
      assign node[WIDTH-1:1] = raw_gp[WIDTH-1:1];
    end else begin : g_pfx
      for (genvar i = 0; i < WIDTH; i++) begin : g_node
        if (bk_is_node(l, i, LOG2W)) begin : g_cell
          localparam int SPAN = bk_span(l, LOG2W);
          bka_gp_cell u_cell (
            .hi_i (g_lvl[l-1].g_cut.src[i]),
            .lo_i (g_lvl[l-1].g_cut.src[i-SPAN]),
            .gp_o (node[i])
          );
        end else begin : g_pass
          assign node[i] = g_lvl[l-1].g_cut.src[i];
        end
      end
    end

    if (l < LEVELS) begin : g_cut
      gp_t [WIDTH-1:0] src;
      if (level_rank(l, LEVELS, STAGES) != 0) begin : g_reg
        gp_t [WIDTH-1:0] gp_q;
        // Intermediate rank of the prefix tree: hold on stall, else advance.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)      gp_q <= '0;
          else if (!stall) gp_q <= node;
        end
        assign src = gp_q;
      end else begin : g_wire
        assign src = node;
      end
    end
  end

  // Sideband registers of ranks 1..STAGES-1, in step with the prefix ranks.
  for (genvar k = 1; k < STAGES; k++) begin : g_rank
    side_t side_q;
    // Hold on stall, otherwise take the beat (or bubble) from the rank before.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      side_q <= '0;
      else if (!stall) side_q <= side[k-1];
    end
    assign side[k] = side_q;
  end

  assign last = side[STAGES-1];
  assign fin  = g_lvl[LEVELS].node;

  // Split the final prefix results; group propagates are not needed.
  always_comb begin
    fin_g = '0;
    fin_p = '0;
    for (int i = 0; i < WIDTH; i++) begin
      fin_g[i] = fin[i].g;
      fin_p[i] = fin[i].p;
    end
  end
  assign unused_fin_p = ^fin_p;

  assign carry  = {fin_g[WIDTH-2:0], last.cin};
  assign sum_d  = last.p ^ carry;
  assign cout_d = fin_g[WIDTH-1];

  // Output rank: registered result, frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (!stall) begin
      valid_q <= last.valid;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

`ifdef BKA_PIPE_OVF_EN
  logic ovf_q;
  logic ovf_d;

  assign ovf_d = (last.sa == last.sb) && (sum_d[WIDTH-1] != last.sa);

  // Overflow flag follows the same rank and stall timing as the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ovf_q <= 1'b0;
    else if (!stall) ovf_q <= ovf_d;
  end

  assign bus.ovf = ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bka_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_bka_pipe
// Description : Self-checking bench for bka_pipe: directed vector table on
//               a 16-bit/2-rank instance, stall and reset sequences, and a
//               randomised scoreboard run on a 32-bit/4-rank instance.
//               Checks ovf when BKA_PIPE_OVF_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bka_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bka_pipe_if #(.WIDTH(16)) bus16 ();
  bka_pipe_if #(.WIDTH(32)) bus32 ();

  bka_pipe #(.WIDTH(16), .STAGES(2)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  bka_pipe #(.WIDTH(32), .STAGES(4)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;
  logic [33:0] sb_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic v);
    bus16.a = a;
    bus16.b = b;
    bus16.cin = cin;
    bus16.in_valid = v;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [32:0] full;
    logic        eovf;
    logic [33:0] head;
    int          accepted;
    int          cyc;
    int          lat;

    vecs[0]  = '{16'h1234, 16'h5678, 1'b0, 16'h68AC, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[3]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[4]  = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0};
    vecs[5]  = '{16'h7FFF, 16'h0001, 1'b1, 16'h8001, 1'b0, 1'b1};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7]  = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[8]  = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{16'h0001, 16'h7FFF, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[10] = '{16'h4321, 16'h8765, 1'b0, 16'hCA86, 1'b0, 1'b0};
    vecs[11] = '{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0};
    vecs[12] = '{16'h1234, 16'h5678, 1'b1, 16'h68AD, 1'b0, 1'b0};

    drive16(16'h0, 16'h0, 1'b0, 1'b0);
    bus16.out_ready = 1'b1;
    bus32.in_valid = 1'b0;
    bus32.a = '0;
    bus32.b = '0;
    bus32.cin = 1'b0;
    bus32.out_ready = 1'b1;
    rst_n = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_out_valid", bus16.out_valid, 1'b0);
    check("rst_in_ready", bus16.in_ready, 1'b1);
    check("rst_sum", bus16.sum, 16'h0);
    check("rst_cout", bus16.cout, 1'b0);
    check("rst_out_valid32", bus32.out_valid, 1'b0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", bus16.in_ready, 1'b1);

    // Back-to-back vector table; each result appears two cycles after drive
    for (int c = 0; c < NV + 2; c++) begin
      if (c < NV) drive16(vecs[c].a, vecs[c].b, vecs[c].cin, 1'b1);
      else        bus16.in_valid = 1'b0;
      if (c >= 2) begin
        check($sformatf("tbl%0d_valid", c - 2), bus16.out_valid, 1'b1);
        check($sformatf("tbl%0d_sum", c - 2), bus16.sum, vecs[c-2].sum);
        check($sformatf("tbl%0d_cout", c - 2), bus16.cout, vecs[c-2].cout);
`ifdef BKA_PIPE_OVF_EN
        check($sformatf("tbl%0d_ovf", c - 2), bus16.ovf, vecs[c-2].ovf);
`endif
      end else begin
        check($sformatf("tbl_lat_c%0d_valid", c), bus16.out_valid, 1'b0);
      end
      tick();
    end
    check("tbl_drained", bus16.out_valid, 1'b0);

    // Stall: result held for several cycles, no loss or duplication
    bus16.out_ready = 1'b0;
    drive16(16'h7FFF, 16'h0001, 1'b1, 1'b1);
    check("stall_pre_ready", bus16.in_ready, 1'b1);
    tick();
    drive16(16'h1111, 16'h2222, 1'b0, 1'b1);
    tick();
    for (int h = 0; h < 3; h++) begin
      drive16(16'h0005, 16'h0003, 1'b0, 1'b1);
      check($sformatf("stall%0d_valid", h), bus16.out_valid, 1'b1);
      check($sformatf("stall%0d_sum", h), bus16.sum, 16'h8001);
      check($sformatf("stall%0d_cout", h), bus16.cout, 1'b0);
      check($sformatf("stall%0d_in_ready", h), bus16.in_ready, 1'b0);
`ifdef BKA_PIPE_OVF_EN
      check($sformatf("stall%0d_ovf", h), bus16.ovf, 1'b1);
`endif
      tick();
    end
    bus16.out_ready = 1'b1;
    #1;
    check("stall_release_in_ready", bus16.in_ready, 1'b1);
    check("stall_release_sum", bus16.sum, 16'h8001);
    tick();
    bus16.in_valid = 1'b0;
    check("after_stall_b_valid", bus16.out_valid, 1'b1);
    check("after_stall_b_sum", bus16.sum, 16'h3333);
    tick();
    check("after_stall_c_valid", bus16.out_valid, 1'b1);
    check("after_stall_c_sum", bus16.sum, 16'h0008);
    tick();
    check("after_stall_empty", bus16.out_valid, 1'b0);

    // Asynchronous reset with beats in flight
    drive16(16'h1111, 16'h1111, 1'b0, 1'b1);
    tick();
    drive16(16'h2222, 16'h2222, 1'b0, 1'b1);
    tick();
    bus16.in_valid = 1'b0;
    check("prereset_valid", bus16.out_valid, 1'b1);
    check("prereset_sum", bus16.sum, 16'h2222);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus16.out_valid, 1'b0);
    check("arst_sum", bus16.sum, 16'h0);
    check("arst_cout", bus16.cout, 1'b0);
    check("arst_in_ready", bus16.in_ready, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      tick();
      check($sformatf("postrst%0d_valid", r), bus16.out_valid, 1'b0);
    end
    check("postrst_in_ready", bus16.in_ready, 1'b1);

    // 32-bit / 4-rank latency with no stall
    bus32.a = 32'hDEADBEEF;
    bus32.b = 32'h21524111;
    bus32.cin = 1'b1;
    bus32.in_valid = 1'b1;
    tick();
    lat = 1;
    bus32.in_valid = 1'b0;
    while (!bus32.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check("lat32", lat, 4);
    check("lat32_sum", bus32.sum, 32'h00000001);
    check("lat32_cout", bus32.cout, 1'b1);
    tick();
    check("lat32_empty", bus32.out_valid, 1'b0);

    // Random traffic on the 32-bit instance against a scoreboard
    accepted = 0;
    cyc = 0;
    while (accepted < 10000 && cyc < 60000) begin
      bus32.in_valid  = ($urandom_range(0, 3) != 0);
      bus32.a         = $urandom;
      bus32.b         = $urandom;
      bus32.cin       = 1'($urandom_range(0, 1));
      bus32.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus32.out_valid && bus32.out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rnd_unexpected: got result %0h, expected no result", bus32.sum);
        end else begin
          head = sb_q.pop_front();
          check("rnd_sum", bus32.sum, head[31:0]);
          check("rnd_cout", bus32.cout, head[32]);
`ifdef BKA_PIPE_OVF_EN
          check("rnd_ovf", bus32.ovf, head[33]);
`endif
        end
      end
      if (bus32.in_valid && bus32.in_ready) begin
        full = {1'b0, bus32.a} + {1'b0, bus32.b} + {32'h0, bus32.cin};
        eovf = (bus32.a[31] == bus32.b[31]) && (full[31] != bus32.a[31]);
        sb_q.push_back({eovf, full});
        accepted++;
      end
      tick();
      cyc++;
    end
    check("rnd_accepted", accepted, 10000);

    bus32.in_valid = 1'b0;
    bus32.out_ready = 1'b1;
    for (int d = 0; d < 20; d++) begin
      if (bus32.out_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rnd_drain_unexpected: got result %0h, expected no result", bus32.sum);
        end else begin
          head = sb_q.pop_front();
          check("rnd_drain_sum", bus32.sum, head[31:0]);
          check("rnd_drain_cout", bus32.cout, head[32]);
        end
      end
      tick();
    end
    check("rnd_queue_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
